// File: rtl/icache_refill_writer.sv
// icache_refill_writer
//   Refill stage in front of the icache data RAM write port. It accepts a line
//   refill request, issues one L2 line read, packs pairs of half-width L2 beats
//   into full RAM words and writes them with full byte enables. At line end it
//   reports done (plus a sticky error flag) to the icache controller.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   refill_req_i/gnt_o  request handshake from the controller (grant only in IDLE)
//   refill_index_i      line index in the data RAM
//   refill_l2addr_i     line-aligned L2 byte address
//   l2_req_o/addr_o     L2 line-read request, address held while requesting
//   l2_gnt_i            L2 accepts the request
//   l2_rvalid_i/rdata_i/rerr_i   returned beats (error qualified by valid)
//   ram_req_o/write_o/waddr_o/wdata_o/be_o   data RAM write port
//   refill_done_o/err_o one-cycle completion pulse with line error status
//
// Optional build macro ICACHE_REFILL_PERF_EN adds saturating counters
//   perf_refills_o (completed lines) and perf_err_o (lines with an error).
module icache_refill_writer #(
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned ADDR_WIDTH     = 7,
  parameter int unsigned WORDS_PER_LINE = 4,
  parameter int unsigned L2_ADDR_WIDTH  = 32,
  localparam int unsigned BEAT_W = DATA_WIDTH / 2,
  localparam int unsigned WOFF_W = $clog2(WORDS_PER_LINE),
  localparam int unsigned IDX_W  = ADDR_WIDTH - WOFF_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      refill_req_i,
  output logic                      refill_gnt_o,
  input  logic [IDX_W-1:0]          refill_index_i,
  input  logic [L2_ADDR_WIDTH-1:0]  refill_l2addr_i,
  output logic                      l2_req_o,
  output logic [L2_ADDR_WIDTH-1:0]  l2_addr_o,
  input  logic                      l2_gnt_i,
  input  logic                      l2_rvalid_i,
  input  logic [BEAT_W-1:0]         l2_rdata_i,
  input  logic                      l2_rerr_i,
  output logic                      ram_req_o,
  output logic                      ram_write_o,
  output logic [ADDR_WIDTH-1:0]     ram_waddr_o,
  output logic [DATA_WIDTH-1:0]     ram_wdata_o,
  output logic [DATA_WIDTH/8-1:0]   ram_be_o,
  output logic                      refill_done_o,
`ifdef ICACHE_REFILL_PERF_EN
  output logic [31:0]               perf_refills_o,
  output logic [15:0]               perf_err_o,
`endif
  output logic                      refill_err_o
);

  localparam int unsigned NBEATS = 2 * WORDS_PER_LINE;
  localparam int unsigned CNT_W  = $clog2(NBEATS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DATA,
    S_DONE
  } state_t;

  state_t                     r_state;
  state_t                     w_state_next;
  logic [CNT_W-1:0]           r_cnt;
  logic                       r_err;
  logic                       r_pair_err;
  logic [BEAT_W-1:0]          r_lo;
  logic [IDX_W-1:0]           r_index;
  logic [L2_ADDR_WIDTH-1:0]   r_l2addr;
  logic                       r_wr;
  logic [ADDR_WIDTH-1:0]      r_waddr;
  logic [DATA_WIDTH-1:0]      r_wdata;
  logic                       w_beat;
  logic                       w_last;

  // Beats are only meaningful in DATA; stale beats in IDLE/REQ are dropped.
  assign w_beat = (r_state == S_DATA) && l2_rvalid_i;
  assign w_last = w_beat && (r_cnt == CNT_W'(NBEATS - 1));

  always_comb begin
    w_state_next  = r_state;
    refill_gnt_o  = 1'b0;
    l2_req_o      = 1'b0;
    l2_addr_o     = '0;
    refill_done_o = 1'b0;
    refill_err_o  = 1'b0;
    case (r_state)
      S_IDLE: begin
        refill_gnt_o = 1'b1;
        if (refill_req_i) w_state_next = S_REQ;
      end
      S_REQ: begin
        l2_req_o  = 1'b1;
        l2_addr_o = r_l2addr;
        if (l2_gnt_i) w_state_next = S_DATA;
      end
      S_DATA: begin
        if (w_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        refill_done_o = 1'b1;
        refill_err_o  = r_err;
        w_state_next  = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_err      <= 1'b0;
      r_pair_err <= 1'b0;
      r_lo       <= '0;
      r_index    <= '0;
      r_l2addr   <= '0;
      r_wr       <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
    end else begin
      r_state <= w_state_next;
      r_wr    <= 1'b0;
      if ((r_state == S_IDLE) && refill_req_i) begin
        r_index  <= refill_index_i;
        r_l2addr <= refill_l2addr_i;
        r_err    <= 1'b0;
      end
      if (w_beat) begin
        // Counter width is exactly log2(NBEATS), so the last beat wraps it to 0.
        r_cnt <= r_cnt + CNT_W'(1);
        if (l2_rerr_i) r_err <= 1'b1;
        if (!r_cnt[0]) begin
          r_lo       <= l2_rdata_i;
          r_pair_err <= l2_rerr_i;
        end else begin
          // A word is written only if both of its beats arrived clean.
          r_wr    <= !(l2_rerr_i || r_pair_err);
          r_waddr <= {r_index, r_cnt[CNT_W-1:1]};
          r_wdata <= {l2_rdata_i, r_lo};
        end
      end
    end
  end

  assign ram_req_o   = r_wr;
  assign ram_write_o = r_wr;
  assign ram_waddr_o = r_wr ? r_waddr : '0;
  assign ram_wdata_o = r_wr ? r_wdata : '0;
  assign ram_be_o    = {(DATA_WIDTH/8){r_wr}};

`ifdef ICACHE_REFILL_PERF_EN
  logic [31:0] r_perf_refills;
  logic [15:0] r_perf_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_refills <= '0;
      r_perf_err     <= '0;
    end else if (r_state == S_DONE) begin
      if (r_perf_refills != '1) r_perf_refills <= r_perf_refills + 32'd1;
      if (r_err && (r_perf_err != '1)) r_perf_err <= r_perf_err + 16'd1;
    end
  end

  assign perf_refills_o = r_perf_refills;
  assign perf_err_o     = r_perf_err;
`endif

endmodule

// File: tb/tb_icache_refill_writer.sv
module tb_icache_refill_writer;

  localparam int unsigned DW   = 64;
  localparam int unsigned AW   = 7;
  localparam int unsigned WPL  = 4;
  localparam int unsigned L2AW = 32;
  localparam int unsigned BW   = DW / 2;
  localparam int unsigned NB   = 2 * WPL;
  localparam int unsigned IW   = AW - $clog2(WPL);

  logic            clk = 1'b0;
  logic            rst;
  logic            refill_req_i;
  logic            refill_gnt_o;
  logic [IW-1:0]   refill_index_i;
  logic [L2AW-1:0] refill_l2addr_i;
  logic            l2_req_o;
  logic [L2AW-1:0] l2_addr_o;
  logic            l2_gnt_i;
  logic            l2_rvalid_i;
  logic [BW-1:0]   l2_rdata_i;
  logic            l2_rerr_i;
  logic            ram_req_o;
  logic            ram_write_o;
  logic [AW-1:0]   ram_waddr_o;
  logic [DW-1:0]   ram_wdata_o;
  logic [DW/8-1:0] ram_be_o;
  logic            refill_done_o;
  logic            refill_err_o;
`ifdef ICACHE_REFILL_PERF_EN
  logic [31:0]     perf_refills_o;
  logic [15:0]     perf_err_o;
`endif

  icache_refill_writer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WORDS_PER_LINE(WPL), .L2_ADDR_WIDTH(L2AW)
  ) dut (
    .clk(clk), .rst(rst),
    .refill_req_i(refill_req_i), .refill_gnt_o(refill_gnt_o),
    .refill_index_i(refill_index_i), .refill_l2addr_i(refill_l2addr_i),
    .l2_req_o(l2_req_o), .l2_addr_o(l2_addr_o), .l2_gnt_i(l2_gnt_i),
    .l2_rvalid_i(l2_rvalid_i), .l2_rdata_i(l2_rdata_i), .l2_rerr_i(l2_rerr_i),
    .ram_req_o(ram_req_o), .ram_write_o(ram_write_o), .ram_waddr_o(ram_waddr_o),
    .ram_wdata_o(ram_wdata_o), .ram_be_o(ram_be_o),
    .refill_done_o(refill_done_o),
`ifdef ICACHE_REFILL_PERF_EN
    .perf_refills_o(perf_refills_o), .perf_err_o(perf_err_o),
`endif
    .refill_err_o(refill_err_o)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned exp_refills = 0;
  int unsigned exp_errlines = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int unsigned   cyc;
  } wr_t;

  typedef struct {
    logic        err;
    int unsigned cyc;
  } done_t;

  wr_t   wq[$];
  done_t dq[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every RAM write and done pulse must match the next expected entry.
  always @(negedge clk) begin
    if (ram_req_o) begin
      if (wq.size() == 0) begin
        chk("unexpected_ram_write_addr", 64'(ram_waddr_o), 64'hFFFF);
      end else begin
        wr_t e;
        e = wq.pop_front();
        chk("ram_waddr", 64'(ram_waddr_o), 64'(e.addr));
        chk("ram_wdata", ram_wdata_o, e.data);
        chk("ram_write_cycle", 64'(cyc), 64'(e.cyc));
        chk("ram_write_o", 64'(ram_write_o), 64'd1);
        chk("ram_be", 64'(ram_be_o), 64'hFF);
      end
    end
    if (refill_done_o) begin
      if (dq.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        done_t d;
        d = dq.pop_front();
        chk("refill_err", 64'(refill_err_o), 64'(d.err));
        chk("done_cycle", 64'(cyc), 64'(d.cyc));
      end
    end
  end

  // One line refill. gap: -1 random gaps, else fixed gap cycles between beats.
  // rst_after: beat number after which reset is pulsed (-1 none).
  task automatic refill(input logic [IW-1:0] idx, input logic [L2AW-1:0] addr,
                        input int gdly, input int gap, input logic [NB-1:0] emask,
                        input int rst_after, input bit stale);
    logic [BW-1:0] beats[NB];
    int unsigned   n;
    for (int b = 0; b < NB; b++) beats[b] = (idx == 3 && addr == 32'h1000) ? BW'(b) : $urandom;
    n = 0;
    while (!refill_gnt_o && n < 50) begin
      tick;
      n++;
    end
    if (n == 50) chk("wait_gnt_timeout", 64'd0, 64'd1);
    refill_req_i    = 1'b1;
    refill_index_i  = idx;
    refill_l2addr_i = addr;
    tick;
    refill_req_i    = 1'b0;
    refill_index_i  = IW'($urandom);
    refill_l2addr_i = $urandom;
    for (int d = 0; d <= gdly; d++) begin
      chk("l2_req_o", 64'(l2_req_o), 64'd1);
      chk("l2_addr_o", 64'(l2_addr_o), 64'(addr));
      l2_rvalid_i = stale;
      l2_rdata_i  = $urandom;
      l2_gnt_i    = (d == gdly);
      tick;
    end
    l2_gnt_i    = 1'b0;
    l2_rvalid_i = 1'b0;
    for (int b = 0; b < NB; b++) begin
      int g;
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      for (int k = 0; k < g; k++) begin
        l2_rvalid_i = 1'b0;
        l2_rdata_i  = $urandom;
        l2_rerr_i   = $urandom;
        tick;
      end
      l2_rvalid_i = 1'b1;
      l2_rdata_i  = beats[b];
      l2_rerr_i   = emask[b];
      // A word lands one cycle after its odd beat, and only if both beats are clean.
      if ((b % 2) == 1 && !emask[b] && !emask[b-1]) begin
        wr_t w;
        w.addr = AW'(int'(idx) * WPL + b / 2);
        w.data = {beats[b], beats[b-1]};
        w.cyc  = cyc + 1;
        wq.push_back(w);
      end
      if (b == NB - 1) begin
        done_t dn;
        dn.err = |emask;
        dn.cyc = cyc + 1;
        dq.push_back(dn);
        exp_refills++;
        if (|emask) exp_errlines++;
      end
      tick;
      l2_rvalid_i = 1'b0;
      l2_rerr_i   = 1'b0;
      if (b == rst_after) begin
        rst = 1'b1;
        tick;
        rst = 1'b0;
        exp_refills  = 0;
        exp_errlines = 0;
        chk("post_rst_ram_req", 64'(ram_req_o), 64'd0);
        chk("post_rst_done", 64'(refill_done_o), 64'd0);
        chk("post_rst_l2_req", 64'(l2_req_o), 64'd0);
        chk("post_rst_wdata", ram_wdata_o, 64'd0);
        return;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    refill_req_i = 1'b0; refill_index_i = '0; refill_l2addr_i = '0;
    l2_gnt_i = 1'b0; l2_rvalid_i = 1'b0; l2_rdata_i = '0; l2_rerr_i = 1'b0;
    tick; tick; tick;
    chk("rst_gnt", 64'(refill_gnt_o), 64'd1);
    chk("rst_l2_req", 64'(l2_req_o), 64'd0);
    chk("rst_ram_req", 64'(ram_req_o), 64'd0);
    chk("rst_be", 64'(ram_be_o), 64'd0);
    chk("rst_done", 64'(refill_done_o), 64'd0);
    rst = 1'b0;
    tick;

    refill(IW'(3), 32'h1000, 2, 0, '0, -1, 1'b0);
    refill(IW'(3), 32'h1000, 2, 1, '0, -1, 1'b0);
    refill(IW'(3), 32'h1000, 0, 0, NB'(8'b0000_0100), -1, 1'b0);
    refill(IW'(5), 32'h2000, 1, 0, '0, 3, 1'b0);
    refill(IW'(0), 32'h3000, 1, 0, '0, -1, 1'b0);

    // Stale beats while idle and during REQ must be ignored.
    tick; tick;
    for (int i = 0; i < 3; i++) begin
      l2_rvalid_i = 1'b1;
      l2_rdata_i  = $urandom;
      tick;
    end
    l2_rvalid_i = 1'b0;
    refill(IW'(7), 32'h4000, 3, 0, '0, -1, 1'b1);

    for (int t = 0; t < 20; t++) begin
      logic [NB-1:0] em;
      em = '0;
      for (int b = 0; b < NB; b++) em[b] = ($urandom_range(0, 11) == 0);
      refill(IW'($urandom), $urandom & 32'hFFFF_FFE0, int'($urandom_range(0, 3)), -1, em, -1,
             bit'($urandom_range(0, 1)));
    end

    tick; tick; tick;
    chk("pending_writes", 64'(wq.size()), 64'd0);
    chk("pending_done", 64'(dq.size()), 64'd0);
`ifdef ICACHE_REFILL_PERF_EN
    chk("perf_refills", 64'(perf_refills_o), 64'(exp_refills));
    chk("perf_err", 64'(perf_err_o), 64'(exp_errlines));
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
